multicycle_control_unit: RTL and testbench

- Moore/Mealy FSM that sequences the multicycle RISC-V datapath: PC, IR, register file, ALU and a shared instruction/data memory port.
- Decodes the opcode held in the IR and issues per-cycle datapath strobes. Memory accesses use a ready handshake.
- Unsupported encodings and memory timeouts land in a sticky TRAP state.

---
 rtl/multicycle_control_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - control FSM sequencing a multicycle RISC-V datapath
//
// Purpose: decodes the opcode held in the IR and issues per-cycle datapath
// strobes for fetch, decode, execute, memory and writeback phases. Memory
// accesses wait on i_mem_ready with a bounded wait; unsupported encodings and
// memory timeouts end in a sticky TRAP state.
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), async active-low reset
//   i_opcode, i_funct3, i_funct7_5 instruction fields from the IR
//   i_zero                         ALU result is zero
//   i_mem_ready                    memory completes the current access
//   o_reset_wire                   datapath synchronous clear
//   o_pc_write, o_pc_src           PC load enable / next-PC select
//   o_ir_write, o_target_write     IR / branch-target register load enables
//   o_mem_rd, o_mem_wr, o_addr_sel memory request strobes / address select
//   o_reg_write, o_wb_sel          register-file write enable / writeback select
//   o_alu_src_a, o_alu_src_b       ALU operand selects
//   o_operacao                     ALU operation
//   o_halted, o_state_dbg          trap indicator / current state encoding

module multicycle_control_unit #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_reset_wire,
  output logic       o_pc_write,
  output logic       o_pc_src,
  output logic       o_ir_write,
  output logic       o_target_write,
  output logic       o_mem_rd,
  output logic       o_mem_wr,
  output logic       o_addr_sel,
  output logic       o_reg_write,
  output logic [1:0] o_wb_sel,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [2:0] o_operacao,
  output logic       o_halted,
  output logic [3:0] o_state_dbg
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_ALU_WB = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_LD_WB  = 4'd7,
    S_MEM_WR = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_XOR  = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;

  // Count value seen in the last allowed waiting cycle.
  localparam logic [CNT_W-1:0] LP_WAIT_LAST = (WAIT_MAX > 0) ? CNT_W'(WAIT_MAX - 1) : '0;
  localparam bit               LP_TIMEOUT_EN = (WAIT_MAX > 0);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_wait_cnt;

  logic w_is_r, w_is_i, w_is_lui, w_is_load, w_is_store, w_is_branch, w_is_jal;
  logic w_f3_alu_ok;
  logic w_mem_state;
  logic w_timeout;
  logic [2:0] w_alu_op;

  assign w_is_r      = (i_opcode == OP_R);
  assign w_is_i      = (i_opcode == OP_I);
  assign w_is_lui    = (i_opcode == OP_LUI);
  assign w_is_load   = (i_opcode == OP_LOAD);
  assign w_is_store  = (i_opcode == OP_STORE);
  assign w_is_branch = (i_opcode == OP_BRANCH);
  assign w_is_jal    = (i_opcode == OP_JAL);

  assign w_f3_alu_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b010) || (i_funct3 == 3'b100) ||
                       (i_funct3 == 3'b110) || (i_funct3 == 3'b111);

  assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);

  // A ready in the final waiting cycle still completes the access.
  assign w_timeout = LP_TIMEOUT_EN && w_mem_state && !i_mem_ready && (r_wait_cnt == LP_WAIT_LAST);

  // funct7_5 selects subtract only for register-register ops; addi ignores it.
  always_comb begin
    w_alu_op = ALU_NONE;
    case (i_funct3)
      3'b000:  w_alu_op = (w_is_r && i_funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  w_alu_op = ALU_SLT;
      3'b100:  w_alu_op = ALU_XOR;
      3'b110:  w_alu_op = ALU_OR;
      3'b111:  w_alu_op = ALU_AND;
      default: w_alu_op = ALU_NONE;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:  w_next = S_FETCH;
      S_FETCH: begin
        if (i_mem_ready)    w_next = S_DECODE;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_DECODE: begin
        if (w_is_r || w_is_i)            w_next = w_f3_alu_ok ? S_EXEC : S_TRAP;
        else if (w_is_lui)               w_next = S_EXEC;
        else if (w_is_load || w_is_store) w_next = S_ADDR;
        else if (w_is_branch)            w_next = S_BRANCH;
        else if (w_is_jal)               w_next = S_JUMP;
        else                             w_next = S_TRAP;
      end
      S_EXEC:   w_next = S_ALU_WB;
      S_ALU_WB: w_next = S_FETCH;
      S_ADDR:   w_next = w_is_load ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (i_mem_ready)    w_next = S_LD_WB;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_LD_WB:  w_next = S_FETCH;
      S_MEM_WR: begin
        if (i_mem_ready)    w_next = S_FETCH;
        else if (w_timeout) w_next = S_TRAP;
      end
      S_BRANCH: w_next = (i_funct3[2:1] == 2'b00) ? S_FETCH : S_TRAP;
      S_JUMP:   w_next = S_FETCH;
      S_TRAP:   w_next = S_TRAP;
      default:  w_next = S_TRAP;
    endcase
  end

  // Any state change clears the wait count, so every memory state is entered
  // with a fresh budget; it only advances while a request is left pending.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_RESET;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_mem_state && !i_mem_ready)
        r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Strobes decode from the registered state so an asynchronous reset
  // removes any in-flight request in the same instant.
  always_comb begin
    o_reset_wire   = 1'b0;
    o_pc_write     = 1'b0;
    o_pc_src       = 1'b0;
    o_ir_write     = 1'b0;
    o_target_write = 1'b0;
    o_mem_rd       = 1'b0;
    o_mem_wr       = 1'b0;
    o_addr_sel     = 1'b0;
    o_reg_write    = 1'b0;
    o_wb_sel       = 2'b00;
    o_alu_src_a    = 2'b00;
    o_alu_src_b    = 2'b00;
    o_operacao     = ALU_NONE;
    o_halted       = 1'b0;
    case (r_state)
      S_RESET: o_reset_wire = 1'b1;
      S_FETCH: begin
        o_mem_rd    = 1'b1;
        o_alu_src_b = 2'b01;
        o_operacao  = ALU_ADD;
        o_ir_write  = i_mem_ready;
        o_pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_alu_src_a    = 2'b10;
        o_alu_src_b    = 2'b10;
        o_operacao     = ALU_ADD;
        o_target_write = 1'b1;
      end
      S_EXEC: begin
        if (w_is_lui) begin
          o_alu_src_a = 2'b11;
          o_alu_src_b = 2'b10;
          o_operacao  = ALU_ADD;
        end else begin
          o_alu_src_a = 2'b01;
          o_alu_src_b = w_is_r ? 2'b00 : 2'b10;
          o_operacao  = w_alu_op;
        end
      end
      S_ALU_WB: o_reg_write = 1'b1;
      S_ADDR: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b10;
        o_operacao  = ALU_ADD;
      end
      S_MEM_RD: begin
        o_mem_rd   = 1'b1;
        o_addr_sel = 1'b1;
      end
      S_LD_WB: begin
        o_reg_write = 1'b1;
        o_wb_sel    = 2'b01;
      end
      S_MEM_WR: begin
        o_mem_wr   = 1'b1;
        o_addr_sel = 1'b1;
      end
      S_BRANCH: begin
        o_alu_src_a = 2'b01;
        o_operacao  = ALU_SUB;
        o_pc_src    = 1'b1;
        if (i_funct3 == 3'b000)      o_pc_write = i_zero;
        else if (i_funct3 == 3'b001) o_pc_write = !i_zero;
      end
      S_JUMP: begin
        o_pc_write  = 1'b1;
        o_pc_src    = 1'b1;
        o_reg_write = 1'b1;
        o_wb_sel    = 2'b10;
      end
      S_TRAP:  o_halted = 1'b1;
      default: o_halted = 1'b1;
    endcase
  end

  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit

module tb_multicycle_control_unit;

  localparam int WAIT_MAX = 15;

  localparam bit [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;
  localparam bit [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011;
  localparam bit [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

  localparam int ST_RESET = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC = 3, ST_ALU_WB = 4;
  localparam int ST_ADDR = 5, ST_MEM_RD = 6, ST_LD_WB = 7, ST_MEM_WR = 8;
  localparam int ST_BRANCH = 9, ST_JUMP = 10, ST_TRAP = 11;

  typedef struct {
    bit        rstn;
    bit        rdy;
    bit [6:0]  opc;
    bit [2:0]  f3;
    bit        f7;
    bit        z;
    bit [3:0]  st;
    bit [18:0] outs;
  } item_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic       funct7_5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       reset_wire, pc_write, pc_src, ir_write, target_write;
  logic       mem_rd, mem_wr, addr_sel, reg_write, halted;
  logic [1:0] wb_sel, alu_src_a, alu_src_b;
  logic [2:0] operacao;
  logic [3:0] state_dbg;

  item_t stim_q[$];
  item_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  bit [2:0] ok_f3 [5] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
  bit [2:0] bad_f3 [3] = '{3'd1, 3'd3, 3'd5};

  multicycle_control_unit #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct3(funct3),
    .i_funct7_5(funct7_5), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_reset_wire(reset_wire), .o_pc_write(pc_write), .o_pc_src(pc_src),
    .o_ir_write(ir_write), .o_target_write(target_write), .o_mem_rd(mem_rd),
    .o_mem_wr(mem_wr), .o_addr_sel(addr_sel), .o_reg_write(reg_write),
    .o_wb_sel(wb_sel), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
    .o_operacao(operacao), .o_halted(halted), .o_state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Reference strobes for one cycle spent in state st, from the per-state tables.
  function automatic bit [18:0] outs_for(int st, bit rdy, bit [6:0] opc, bit [2:0] f3, bit f7, bit z);
    bit rw = 0, pw = 0, ps = 0, iw = 0, tw = 0, mr = 0, mw = 0, as = 0, rg = 0, h = 0;
    bit [1:0] wb = 0, a = 0, b = 0;
    bit [2:0] op = 0;
    case (st)
      ST_RESET:  rw = 1;
      ST_FETCH:  begin mr = 1; b = 2'b01; op = 3'b001; iw = rdy; pw = rdy; end
      ST_DECODE: begin a = 2'b10; b = 2'b10; op = 3'b001; tw = 1; end
      ST_EXEC: begin
        if (opc == OP_LUI) begin a = 2'b11; b = 2'b10; op = 3'b001; end
        else begin
          a = 2'b01;
          b = (opc == OP_R) ? 2'b00 : 2'b10;
          case (f3)
            3'd0: op = (opc == OP_R && f7) ? 3'b010 : 3'b001;
            3'd2: op = 3'b110;
            3'd4: op = 3'b101;
            3'd6: op = 3'b100;
            3'd7: op = 3'b011;
            default: op = 3'b000;
          endcase
        end
      end
      ST_ALU_WB: rg = 1;
      ST_ADDR:   begin a = 2'b01; b = 2'b10; op = 3'b001; end
      ST_MEM_RD: begin mr = 1; as = 1; end
      ST_LD_WB:  begin rg = 1; wb = 2'b01; end
      ST_MEM_WR: begin mw = 1; as = 1; end
      ST_BRANCH: begin
        a = 2'b01; op = 3'b010; ps = 1;
        pw = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : 1'b0;
      end
      ST_JUMP:   begin pw = 1; ps = 1; rg = 1; wb = 2'b10; end
      default:   h = 1;
    endcase
    return {rw, pw, ps, iw, tw, mr, mw, as, rg, wb, a, b, op, h};
  endfunction

  task automatic add(bit rstn, bit rdy, int st, bit [6:0] opc, bit [2:0] f3, bit f7, bit z);
    item_t it;
    it.rstn = rstn; it.rdy = rdy; it.opc = opc; it.f3 = f3; it.f7 = f7; it.z = z;
    it.st = 4'(st);
    it.outs = outs_for(st, rdy, opc, f3, f7, z);
    stim_q.push_back(it);
  endtask

  task automatic do_reset(bit [6:0] opc);
    add(1'b0, 1'($urandom_range(0, 1)), ST_RESET, opc, 3'd0, 1'b0, 1'b0);
    add(1'b1, 1'($urandom_range(0, 1)), ST_RESET, opc, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic trap_then_reset(int n, bit [6:0] opc, bit [2:0] f3, bit f7, bit z);
    for (int i = 0; i < n; i++) add(1'b1, 1'($urandom_range(0, 1)), ST_TRAP, opc, f3, f7, z);
    do_reset(opc);
  endtask

  // A memory wait of w idle cycles; timed_out when the budget of WAIT_MAX runs out first.
  task automatic mem_wait(int st, int w, bit [6:0] opc, bit [2:0] f3, bit f7, bit z, output bit timed_out);
    timed_out = (w >= WAIT_MAX);
    for (int i = 0; i < (timed_out ? WAIT_MAX : w); i++) add(1'b1, 1'b0, st, opc, f3, f7, z);
    if (!timed_out) add(1'b1, 1'b1, st, opc, f3, f7, z);
  endtask

  task automatic gen_instr(bit [6:0] opc, bit [2:0] f3, bit f7, bit z, int fw, int mw, int tlen);
    bit to;
    bit f3_ok;
    mem_wait(ST_FETCH, fw, opc, f3, f7, z, to);
    if (to) begin trap_then_reset(tlen, opc, f3, f7, z); return; end
    add(1'b1, 1'($urandom_range(0, 1)), ST_DECODE, opc, f3, f7, z);
    f3_ok = (f3 == 0) || (f3 == 2) || (f3 == 4) || (f3 == 6) || (f3 == 7);
    if (opc == OP_LUI || ((opc == OP_R || opc == OP_I) && f3_ok)) begin
      add(1'b1, 1'($urandom_range(0, 1)), ST_EXEC, opc, f3, f7, z);
      add(1'b1, 1'($urandom_range(0, 1)), ST_ALU_WB, opc, f3, f7, z);
    end else if (opc == OP_LD || opc == OP_ST) begin
      add(1'b1, 1'($urandom_range(0, 1)), ST_ADDR, opc, f3, f7, z);
      mem_wait((opc == OP_LD) ? ST_MEM_RD : ST_MEM_WR, mw, opc, f3, f7, z, to);
      if (to) trap_then_reset(tlen, opc, f3, f7, z);
      else if (opc == OP_LD) add(1'b1, 1'($urandom_range(0, 1)), ST_LD_WB, opc, f3, f7, z);
    end else if (opc == OP_BR) begin
      add(1'b1, 1'($urandom_range(0, 1)), ST_BRANCH, opc, f3, f7, z);
      if (f3 > 3'd1) trap_then_reset(tlen, opc, f3, f7, z);
    end else if (opc == OP_JAL) begin
      add(1'b1, 1'($urandom_range(0, 1)), ST_JUMP, opc, f3, f7, z);
    end else begin
      trap_then_reset(tlen, opc, f3, f7, z);
    end
  endtask

  function automatic bit known_op(bit [6:0] o);
    return (o == OP_R) || (o == OP_I) || (o == OP_LUI) || (o == OP_LD) ||
           (o == OP_ST) || (o == OP_BR) || (o == OP_JAL);
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 2));
  endfunction

  task automatic gen_random(int n);
    bit [6:0] opc;
    bit [2:0] f3;
    for (int k = 0; k < n; k++) begin
      f3 = ok_f3[$urandom_range(0, 4)];
      case ($urandom_range(0, 9))
        0, 9: opc = OP_R;
        1: opc = OP_I;
        2: begin opc = OP_LUI; f3 = 3'($urandom_range(0, 7)); end
        3: opc = OP_LD;
        4: opc = OP_ST;
        5: begin
          opc = OP_BR;
          f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
        end
        6: opc = OP_JAL;
        7: begin
          opc = 7'($urandom_range(0, 127));
          while (known_op(opc)) opc = 7'($urandom_range(0, 127));
        end
        default: begin
          opc = ($urandom_range(0, 1) == 1) ? OP_R : OP_I;
          f3 = bad_f3[$urandom_range(0, 2)];
        end
      endcase
      gen_instr(opc, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                rand_wait(), rand_wait(), int'($urandom_range(1, 4)));
    end
  endtask

  // Driver: applies one stimulus item per cycle just after the rising edge
  // and hands its expected response to the scoreboard.
  initial begin
    item_t it;
    do_reset(OP_R);
    gen_instr(OP_R, 3'd0, 1'b0, 1'b0, 0, 0, 1);
    gen_instr(OP_R, 3'd0, 1'b1, 1'b0, 0, 0, 1);
    gen_instr(OP_LD, 3'd2, 1'b0, 1'b0, 0, 3, 1);
    gen_instr(OP_BR, 3'd0, 1'b0, 1'b1, 0, 0, 1);
    gen_instr(OP_BR, 3'd0, 1'b0, 1'b0, 0, 0, 1);
    gen_instr(OP_BR, 3'd1, 1'b0, 1'b0, 0, 0, 1);
    gen_instr(OP_JAL, 3'd0, 1'b0, 1'b0, 0, 0, 1);
    gen_instr(OP_LUI, 3'd5, 1'b1, 1'b0, 0, 0, 1);
    gen_instr(OP_I, 3'd0, 1'b1, 1'b0, 0, 0, 1);
    gen_instr(7'b1111111, 3'd0, 1'b0, 1'b0, 0, 0, 20);
    gen_instr(OP_R, 3'd7, 1'b0, 1'b0, 14, 0, 1);
    gen_instr(OP_R, 3'd6, 1'b0, 1'b0, 15, 0, 3);
    gen_instr(OP_ST, 3'd2, 1'b0, 1'b0, 0, 14, 1);
    gen_instr(OP_LD, 3'd2, 1'b0, 1'b0, 1, 15, 2);
    add(1'b1, 1'b1, ST_FETCH, OP_ST, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, ST_DECODE, OP_ST, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, ST_ADDR, OP_ST, 3'd2, 1'b0, 1'b0);
    add(1'b1, 1'b0, ST_MEM_WR, OP_ST, 3'd2, 1'b0, 1'b0);
    do_reset(OP_ST);
    gen_random(60);
    while (stim_q.size() > 0) begin
      it = stim_q.pop_front();
      @(posedge clk);
      #1;
      rst_n = it.rstn; mem_ready = it.rdy; opcode = it.opc;
      funct3 = it.f3; funct7_5 = it.f7; zero = it.z;
      exp_q.push_back(it);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor: each falling edge compares the DUT against the oldest expected item.
  always @(negedge clk) begin
    item_t e;
    logic [18:0] got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cyc++;
      got = {reset_wire, pc_write, pc_src, ir_write, target_write, mem_rd, mem_wr, addr_sel,
             reg_write, wb_sel, alu_src_a, alu_src_b, operacao, halted};
      checks += 2;
      if (state_dbg !== e.st) begin
        failures++;
        $display("FAIL state cyc=%0d: got=%0d required=%0d", cyc, state_dbg, e.st);
      end
      if (got !== e.outs) begin
        failures++;
        $display("FAIL outs cyc=%0d st=%0d: got=%b required=%b", cyc, e.st, got, e.outs);
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
